// File: rtl/fod_phe_pkg.sv
// Shared definitions for the FOD phase-error sampler: default geometry, phase index
// type and the circular thermometer decoder used by the sampler and calibration paths.
package fod_phe_pkg;

    localparam int unsigned PHE_SEG_BIN_DEF = 3;
    localparam int unsigned PHE_NLANE_DEF   = 4;

    // Widest decoder supported; instantiations must keep SEG_BIN below PHE_MAX_BIN.
    localparam int unsigned PHE_MAX_BIN = 7;
    localparam int unsigned PHE_MAX_N   = 1 << PHE_MAX_BIN;

    typedef logic [PHE_SEG_BIN_DEF-1:0] phe_idx_t;
    typedef logic [PHE_MAX_BIN-1:0]     phe_idx_max_t;

    // Returns {valid, phase}. Only the low 2**seg_bin bits of word are examined.
    // Valid means exactly one circular 0->1 boundary; phase is the bit that goes high.
    function automatic logic [PHE_MAX_BIN:0] phe_decode(
        input logic [PHE_MAX_N-1:0] word,
        input int unsigned          seg_bin
    );
        int unsigned  n_ph;
        int unsigned  n_bnd;
        phe_idx_max_t prev;
        phe_idx_max_t ph;
        n_ph  = 1 << seg_bin;
        n_bnd = 0;
        ph    = '0;
        for (int unsigned i = 0; i < PHE_MAX_N; i++) begin
            if (i < n_ph) begin
                prev = (i == 0) ? PHE_MAX_BIN'(n_ph - 1) : PHE_MAX_BIN'(i - 1);
                if (word[i[PHE_MAX_BIN-1:0]] && !word[prev]) begin
                    n_bnd = n_bnd + 1;
                    ph    = i[PHE_MAX_BIN-1:0];
                end
            end
        end
        return {(n_bnd == 1), ph};
    endfunction

endpackage

// File: rtl/fod_phe_sampler_xn_decode.sv
// Combinational multiphase-snapshot decoder; the caller registers the result.
module fod_phe_decode
    import fod_phe_pkg::*;
#(
    parameter int unsigned SEG_BIN = PHE_SEG_BIN_DEF
) (
    input  logic [(1<<SEG_BIN)-1:0] psamp,
    output logic                    valid,
    output logic [SEG_BIN-1:0]      phase
);

    logic [PHE_MAX_N-1:0] word;
    logic [PHE_MAX_BIN:0] dec;
    logic                 unused_hi;

    always_comb begin
        word      = PHE_MAX_N'(psamp);
        dec       = phe_decode(word, SEG_BIN);
        valid     = dec[PHE_MAX_BIN];
        phase     = dec[SEG_BIN-1:0];
        // Upper phase bits are always zero for the narrower phase count.
        unused_hi = ^dec[PHE_MAX_BIN-1:SEG_BIN];
    end

endmodule

// File: rtl/fod_phe_sampler_xn.sv
// Phase-error sampler and lane packer: 3-stage pipeline (capture, decode, lane write)
// with frame commit every NLANE EN-tagged samples, frame sum and saturating error count.
module fod_phe_sampler_xn
    import fod_phe_pkg::*;
#(
    parameter int unsigned SEG_BIN = PHE_SEG_BIN_DEF,
    parameter int unsigned NLANE   = PHE_NLANE_DEF,
    parameter int unsigned ERR_W   = 16
) (
    input  logic                              CLK,
    input  logic                              ARST,
    input  logic                              EN,
    input  logic [(1<<SEG_BIN)-1:0]           PSAMP,
    input  logic                              CLR_ERR,
    output logic [NLANE*SEG_BIN-1:0]          PHE_XN,
    output logic [SEG_BIN+$clog2(NLANE)-1:0]  PHE_SUM,
    output logic                              VALID,
    output logic                              FRM_ERR,
    output logic [ERR_W-1:0]                  ERR_CNT
);

    localparam int unsigned N     = 1 << SEG_BIN;
    localparam int unsigned LC_W  = $clog2(NLANE);
    localparam int unsigned SUM_W = SEG_BIN + LC_W;

    logic                     s1_en_q, s1_en_d;
    logic [N-1:0]             s1_psamp_q, s1_psamp_d;
    logic                     s2_en_q, s2_en_d;
    logic                     s2_inv_q, s2_inv_d;
    logic [SEG_BIN-1:0]       s2_phase_q, s2_phase_d;
    logic [SEG_BIN-1:0]       last_q, last_d;
    logic [LC_W-1:0]          lc_q, lc_d;
    logic [SEG_BIN-1:0]       lane_q [NLANE-1];
    logic [SEG_BIN-1:0]       lane_d [NLANE-1];
    logic                     acc_err_q, acc_err_d;
    logic [NLANE*SEG_BIN-1:0] xn_q, xn_d;
    logic [SUM_W-1:0]         sum_q, sum_d;
    logic                     frm_err_q, frm_err_d;
    logic                     valid_q, valid_d;
    logic [ERR_W-1:0]         err_cnt_q, err_cnt_d;

    logic                     dec_valid;
    logic [SEG_BIN-1:0]       dec_phase;
    logic [NLANE*SEG_BIN-1:0] frame;
    logic [SUM_W-1:0]         frame_sum;
    logic                     err_inc;

    fod_phe_decode #(
        .SEG_BIN (SEG_BIN)
    ) u_decode (
        .psamp (s1_psamp_q),
        .valid (dec_valid),
        .phase (dec_phase)
    );

    always_comb begin
        s1_en_d    = EN;
        s1_psamp_d = PSAMP;

        s2_en_d    = s1_en_q;
        s2_inv_d   = ~dec_valid;
        s2_phase_d = dec_valid ? dec_phase : last_q;
        last_d     = (s1_en_q && dec_valid) ? dec_phase : last_q;

        // Last lane is taken straight from stage 2, so the buffer holds NLANE-1 lanes.
        frame     = '0;
        frame_sum = '0;
        for (int unsigned l = 0; l < NLANE - 1; l++) begin
            frame[l*SEG_BIN +: SEG_BIN] = lane_q[l];
            frame_sum = frame_sum + SUM_W'(lane_q[l]);
        end
        frame[(NLANE-1)*SEG_BIN +: SEG_BIN] = s2_phase_q;
        frame_sum = frame_sum + SUM_W'(s2_phase_q);

        lc_d      = lc_q;
        lane_d    = lane_q;
        acc_err_d = acc_err_q;
        xn_d      = xn_q;
        sum_d     = sum_q;
        frm_err_d = frm_err_q;
        valid_d   = 1'b0;

        if (s2_en_q) begin
            if (lc_q == LC_W'(NLANE - 1)) begin
                xn_d      = frame;
                sum_d     = frame_sum;
                frm_err_d = acc_err_q | s2_inv_q;
                valid_d   = 1'b1;
                lc_d      = '0;
                acc_err_d = 1'b0;
            end else begin
                lane_d[lc_q] = s2_phase_q;
                lc_d         = lc_q + 1'b1;
                acc_err_d    = acc_err_q | s2_inv_q;
            end
        end else begin
            lc_d      = '0;
            acc_err_d = 1'b0;
        end

        err_inc   = s2_en_q & s2_inv_q;
        err_cnt_d = err_cnt_q;
        if (CLR_ERR) begin
            err_cnt_d = err_inc ? ERR_W'(1) : '0;
        end else if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            s1_en_q    <= 1'b0;
            s1_psamp_q <= '0;
            s2_en_q    <= 1'b0;
            s2_inv_q   <= 1'b0;
            s2_phase_q <= '0;
            last_q     <= '0;
            lc_q       <= '0;
            for (int unsigned l = 0; l < NLANE - 1; l++) begin
                lane_q[l] <= '0;
            end
            acc_err_q  <= 1'b0;
            xn_q       <= '0;
            sum_q      <= '0;
            frm_err_q  <= 1'b0;
            valid_q    <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_en_q    <= s1_en_d;
            s1_psamp_q <= s1_psamp_d;
            s2_en_q    <= s2_en_d;
            s2_inv_q   <= s2_inv_d;
            s2_phase_q <= s2_phase_d;
            last_q     <= last_d;
            lc_q       <= lc_d;
            lane_q     <= lane_d;
            acc_err_q  <= acc_err_d;
            xn_q       <= xn_d;
            sum_q      <= sum_d;
            frm_err_q  <= frm_err_d;
            valid_q    <= valid_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign PHE_XN  = xn_q;
    assign PHE_SUM = sum_q;
    assign VALID   = valid_q;
    assign FRM_ERR = frm_err_q;
    assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_fod_phe_sampler_xn.sv
// Directed bench for fod_phe_sampler_xn: default 8-phase/4-lane instance with a 4-bit
// error counter, plus a 16-phase/8-lane instance for the wide-parameter case.
module tb_fod_phe_sampler_xn;

    logic        CLK = 1'b0;
    logic        ARST = 1'b0;
    always #5 CLK = ~CLK;

    logic        en = 1'b0;
    logic        clr_err = 1'b0;
    logic [7:0]  psamp = 8'h0F;
    logic [11:0] phe_xn;
    logic [4:0]  phe_sum;
    logic        valid, frm_err;
    logic [3:0]  err_cnt;

    logic        w_en = 1'b0;
    logic        w_clr = 1'b0;
    logic [15:0] w_psamp = 16'h00FF;
    logic [31:0] w_xn;
    logic [6:0]  w_sum;
    logic        w_valid, w_frm_err;
    logic [15:0] w_err;

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [7:0] IDLE = 8'h0F;

    fod_phe_sampler_xn #(.SEG_BIN(3), .NLANE(4), .ERR_W(4)) dut (
        .CLK(CLK), .ARST(ARST), .EN(en), .PSAMP(psamp), .CLR_ERR(clr_err),
        .PHE_XN(phe_xn), .PHE_SUM(phe_sum), .VALID(valid), .FRM_ERR(frm_err),
        .ERR_CNT(err_cnt)
    );

    fod_phe_sampler_xn #(.SEG_BIN(4), .NLANE(8), .ERR_W(16)) dut_w (
        .CLK(CLK), .ARST(ARST), .EN(w_en), .PSAMP(w_psamp), .CLR_ERR(w_clr),
        .PHE_XN(w_xn), .PHE_SUM(w_sum), .VALID(w_valid), .FRM_ERR(w_frm_err),
        .ERR_CNT(w_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [7:0] p);
        en    = e;
        psamp = p;
        @(posedge CLK);
        #1;
    endtask

    task automatic wdrive(input logic e, input logic [15:0] p);
        w_en    = e;
        w_psamp = p;
        @(posedge CLK);
        #1;
    endtask

    logic       en3 [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] ps3 [9] = '{8'h1E, 8'h3C, IDLE, 8'h78, 8'hF0, 8'hE1, 8'hC3, IDLE, IDLE};
    logic [15:0] rot;

    initial begin
        // Reset state
        #2 ARST = 1'b1;
        #1;
        chk("rst_xn", 32'(phe_xn), 32'h0);
        chk("rst_sum", 32'(phe_sum), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_frm", 32'(frm_err), 32'h0);
        chk("rst_err", 32'(err_cnt), 32'h0);
        @(posedge CLK);
        @(posedge CLK);
        #1 ARST = 1'b0;

        // Valid phases 0,1,2,7
        drive(1'b1, 8'h0F);
        drive(1'b1, 8'h1E);
        drive(1'b1, 8'h3C);
        drive(1'b1, 8'h87);
        chk("t1_valid_k", 32'(valid), 32'h0);
        drive(1'b0, IDLE);
        chk("t1_valid_k1", 32'(valid), 32'h0);
        drive(1'b0, IDLE);
        chk("t1_valid_k2", 32'(valid), 32'h1);
        chk("t1_xn", 32'(phe_xn), 32'hE88);
        chk("t1_sum", 32'(phe_sum), 32'd10);
        chk("t1_frm", 32'(frm_err), 32'h0);
        drive(1'b0, IDLE);
        chk("t1_pulse_end", 32'(valid), 32'h0);
        chk("t1_xn_hold", 32'(phe_xn), 32'hE88);

        // Invalid codes hold the last valid phase
        drive(1'b1, 8'h0F);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hF0);
        drive(1'b0, IDLE);
        drive(1'b0, IDLE);
        chk("t2_valid", 32'(valid), 32'h1);
        chk("t2_xn", 32'(phe_xn), 32'h800);
        chk("t2_sum", 32'(phe_sum), 32'd4);
        chk("t2_frm", 32'(frm_err), 32'h1);
        chk("t2_err", 32'(err_cnt), 32'd2);

        // EN gap discards the partial frame
        for (int i = 0; i < 9; i++) begin
            drive(en3[i], ps3[i]);
            chk($sformatf("t3_valid_%0d", i), 32'(valid), (i == 8) ? 32'h1 : 32'h0);
        end
        chk("t3_xn", 32'(phe_xn), 32'hD63);
        chk("t3_sum", 32'(phe_sum), 32'd18);
        chk("t3_frm", 32'(frm_err), 32'h0);
        chk("t3_err", 32'(err_cnt), 32'd2);

        // Error counter saturation and clear priority
        for (int i = 0; i < 20; i++) drive(1'b1, 8'h00);
        drive(1'b0, IDLE);
        drive(1'b0, IDLE);
        chk("t4_valid", 32'(valid), 32'h1);
        chk("t4_frm", 32'(frm_err), 32'h1);
        chk("t4_err_sat", 32'(err_cnt), 32'd15);
        drive(1'b1, 8'h00);
        drive(1'b0, IDLE);
        chk("t4_err_hold", 32'(err_cnt), 32'd15);
        clr_err = 1'b1;
        drive(1'b0, IDLE);
        clr_err = 1'b0;
        chk("t4_clr_with_err", 32'(err_cnt), 32'd1);
        clr_err = 1'b1;
        drive(1'b0, IDLE);
        clr_err = 1'b0;
        chk("t4_clr_alone", 32'(err_cnt), 32'd0);
        drive(1'b1, 8'h00);
        drive(1'b0, IDLE);
        drive(1'b0, IDLE);
        chk("t5_err_pre", 32'(err_cnt), 32'd1);

        // Reset mid-frame
        drive(1'b1, 8'h1E);
        drive(1'b1, 8'h3C);
        #3 ARST = 1'b1;
        en = 1'b0;
        #1;
        chk("t5_xn", 32'(phe_xn), 32'h0);
        chk("t5_sum", 32'(phe_sum), 32'h0);
        chk("t5_valid", 32'(valid), 32'h0);
        chk("t5_frm", 32'(frm_err), 32'h0);
        chk("t5_err", 32'(err_cnt), 32'h0);
        @(posedge CLK);
        @(posedge CLK);
        #1 ARST = 1'b0;
        drive(1'b1, 8'h00);
        chk("t5_valid_s0", 32'(valid), 32'h0);
        drive(1'b1, 8'h1E);
        chk("t5_valid_s1", 32'(valid), 32'h0);
        drive(1'b1, 8'h3C);
        chk("t5_valid_s2", 32'(valid), 32'h0);
        drive(1'b1, 8'h87);
        chk("t5_valid_s3", 32'(valid), 32'h0);
        drive(1'b0, IDLE);
        chk("t5_valid_k1", 32'(valid), 32'h0);
        drive(1'b0, IDLE);
        chk("t5_valid_k2", 32'(valid), 32'h1);
        chk("t5_post_xn", 32'(phe_xn), 32'hE88);
        chk("t5_post_sum", 32'(phe_sum), 32'd10);
        chk("t5_post_frm", 32'(frm_err), 32'h1);
        chk("t5_post_err", 32'(err_cnt), 32'd1);

        // Wide instance: 16 phases, 8 lanes
        rot = 16'h00FF;
        for (int i = 0; i < 8; i++) begin
            wdrive(1'b1, rot);
            chk($sformatf("t6_valid_%0d", i), 32'(w_valid), 32'h0);
            rot = {rot[14:0], rot[15]};
        end
        wdrive(1'b0, 16'h00FF);
        chk("t6_valid_k1", 32'(w_valid), 32'h0);
        wdrive(1'b0, 16'h00FF);
        chk("t6_valid_k2", 32'(w_valid), 32'h1);
        chk("t6_xn", w_xn, 32'h76543210);
        chk("t6_sum", 32'(w_sum), 32'd28);
        chk("t6_frm", 32'(w_frm_err), 32'h0);
        chk("t6_err", 32'(w_err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fod_phe_sampler_xn.md
# fod_phe_sampler_xn

Parametrised phase-error sampler and lane packer for the FOD digital controller. Each CLK cycle it takes the multiphase snapshot of the auxiliary clock, captured by the DTC-output sampler, and decodes the circular thermometer pattern to a binary phase index with bubble detection. It packs NLANE consecutive phases into one wide word for the time-interleaved controller. It replaces the fixed 8-phase/4-lane PHE_X4 path with a width- and lane-generic block that adds invalid-code handling, a per-frame sum and an error counter.

## Interface
Parameters:
- SEG_BIN, 3: phase bits; number of phases N = 2**SEG_BIN.
- NLANE, 4: phases packed per output frame (≥2, power of 2).
- ERR_W, 16: error counter width.

Ports:
- CLK  in  1  sampling clock (FDTC-rate domain).
- ARST  in  1  asynchronous, active-high reset.
- EN  in  1  sample qualifier, travels with PSAMP.
- PSAMP  in  N  sampled multiphase word; bit i = phase i.
- CLR_ERR  in  1  synchronous clear of ERR_CNT.
- PHE_XN  out  NLANE*SEG_BIN  packed frame; lane 0 (oldest) in LSBs.
- PHE_SUM  out  SEG_BIN+log2(NLANE)  unsigned sum of the frame's lanes.
- VALID  out  1  one-cycle pulse; PHE_XN/PHE_SUM updated.
- FRM_ERR  out  1  frame contained ≥1 invalid code; meaningful with VALID.
- ERR_CNT  out  ERR_W  saturating count of invalid codes.

## Operation
- Decode: a valid code has exactly one circular 0→1 boundary. Zero-to-one is indexed as i where PSAMP[i]=1 and PSAMP[(i-1) mod N]=0, and phase = i. Index wrap: PSAMP[N-1] precedes PSAMP[0].
- Invalid code: all-zeros, all-ones, or more than one boundary.
  - Phase takes the last valid phase.
  - The lane is still consumed, so frame cadence is preserved.
  - The invalid code sets the frame error flag and increments ERR_CNT.
- Last-valid-phase register resets to 0.
- ERR_CNT saturates at 2**ERR_W-1.
- CLR_ERR has priority over increment. If CLR_ERR and an error occur in the same cycle, ERR_CNT becomes 1.
- Lane counter LC runs 0..NLANE-1 and advances only on EN-tagged samples reaching stage 2.
  - The sample is written to lane LC.
  - At LC = NLANE-1: frame commits, LC wraps to 0.
- A non-EN sample at stage 2 resets LC to 0 and clears the frame error flag. Any partial frame is discarded and no VALID is issued.
- PHE_SUM is the sum of the committed lanes, with no overflow by construction.
- There is no FSM beyond LC; the block is a 3-stage pipeline plus lane buffer.

## Timing
- Edge k: PSAMP and EN are registered into stage 1.
- Edge k+1: decode result, EN tag and invalid flag are registered into stage 2.
- Edge k+2: lane write and ERR_CNT update. For the last lane, PHE_XN, PHE_SUM and FRM_ERR load and VALID goes high for one cycle.
- Latency from the last sample of a frame to VALID: 3 edges.
- With EN continuously high, VALID pulses every NLANE cycles.
- PHE_XN, PHE_SUM and FRM_ERR hold between VALID pulses.
- Reset (any time, mid-frame included): all pipeline registers, lane buffer, LC, outputs, ERR_CNT and last-valid phase are cleared to 0, and VALID=0. The first frame after release needs NLANE EN samples.

## Structure
- Shared package fod_phe_pkg holds:
  - SEG_BIN/NLANE defaults;
  - the typedef for the phase index;
  - the function `phe_decode`, which returns {valid, phase} for an N-bit word.
- One sub-module: fod_phe_decode. It is combinational, is registered by the parent, and is reusable by the calibration path.
- Parent contains: pipeline, lane buffer, LC, sum adder, error counter.

## Test plan
1. Valid phases, N=8, NLANE=4, EN=1. Stimulus: PSAMP 8'b00001111, 8'b00011110, 8'b00111100, 8'b10000111. Required: phases 0,1,2,7; PHE_XN={3'd7,3'd2,3'd1,3'd0}; PHE_SUM=10; FRM_ERR=0; VALID 3 edges after the 4th sample.
2. Invalid codes. Stimulus: frame 00001111, 00000000, 01010101, 11110000. Required: phases 0,0,0,4; FRM_ERR=1; ERR_CNT=2.
3. EN gap. Stimulus: EN low for 1 cycle after 2 samples, then 4 samples. Required: no VALID for the partial frame; next VALID carries exactly the 4 post-gap phases.
4. Error counter limits, ERR_W=4. Stimulus: 20 invalid codes. Required: ERR_CNT=15. Then CLR_ERR together with one invalid code: required ERR_CNT=1.
5. Reset mid-frame. Stimulus: ARST asserted after 2 samples. Required: all outputs 0 immediately, and the first VALID only after 4 new EN samples plus 3 edges.
6. Parameter sweep SEG_BIN=4, NLANE=8. Stimulus: rotate 16'h00FF left by one each cycle. Required: phases 0..7 packed in order and PHE_SUM=28.
